// File: rtl/upsample_layer_sched.sv
// rtl/upsample_layer_sched.sv - upsample layer scheduler: descriptor queue, validation, engine sequencing, watchdog
module upsample_layer_sched #(
    parameter int WIDTH_FEATURE_SIZE    = 11,
    parameter int WIDTH_CHANNEL_NUM_REG = 10,
    parameter int QUEUE_DEPTH           = 4,
    parameter int TIMEOUT_BITS          = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Cmd_Valid,
    output logic                             Cmd_Ready,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Cmd_Row,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Cmd_Channel,
    input  logic [TIMEOUT_BITS-1:0]          Timeout_Limit,
    input  logic                             Abort,
    output logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    output logic                             Next_Reg,
    output logic                             Start,
    input  logic                             Upsample_Complete,
    output logic                             Busy,
    output logic                             Layer_Done,
    output logic [7:0]                       Layer_Cnt,
    output logic                             Err_Cfg,
    output logic                             Err_Timeout
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int ENTRY_W = WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM_REG;
    localparam logic [PTR_W:0]          PTR_ONE = 1;
    localparam logic [TIMEOUT_BITS-1:0] WD_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_SETTLE = 3'd3,
        S_START  = 3'd4,
        S_RUN    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                           state_q, state_d;
    logic [ENTRY_W-1:0]               mem_q [QUEUE_DEPTH];
    logic [PTR_W:0]                   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]                   rd_ptr_q, rd_ptr_d;
    logic [1:0]                       settle_q, settle_d;
    logic [TIMEOUT_BITS-1:0]          wd_q, wd_d;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_q, row_d;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_q, ch_d;
    logic [7:0]                       cnt_q, cnt_d;
    logic                             err_to_q, err_to_d;

    logic                             q_empty, q_full, push;
    logic [ENTRY_W-1:0]               head;
    logic [WIDTH_FEATURE_SIZE-1:0]    head_row;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] head_ch;
    logic                             head_valid;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // LOAD always pops, so a full queue can still take a descriptor in that cycle
    assign Cmd_Ready = (!q_full || (state_q == S_LOAD)) && !Abort;
    assign push      = Cmd_Valid && Cmd_Ready;

    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_row   = head[ENTRY_W-1 -: WIDTH_FEATURE_SIZE];
    assign head_ch    = head[WIDTH_CHANNEL_NUM_REG-1:0];
    // engine consumes 16 channels per beat, so channel count must be a non-zero multiple of 16
    assign head_valid = (head_row != '0) && (head_ch != '0) && (head_ch[3:0] == 4'd0);

    // descriptor storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {Cmd_Row, Cmd_Channel};
        end
    end

    // next-state logic for the sequencer, queue pointers, watchdog and counters
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        settle_d = settle_q;
        wd_d     = wd_q;
        row_d    = row_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        err_to_d = err_to_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (!q_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (head_valid) begin
                    row_d   = head_row;
                    ch_d    = head_ch;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                settle_d = 2'd0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // four cycles for the engine's pipelined size multipliers
                if (settle_q == 2'd3) state_d = S_START;
                else                  settle_d = settle_q + 2'd1;
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + WD_ONE;
                // completion takes priority over a watchdog expiring in the same cycle
                if (Upsample_Complete) begin
                    state_d = S_DONE;
                end else if ((Timeout_Limit != '0) && (wd_q == Timeout_Limit - WD_ONE)) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort flushes the queue and the timeout flag but keeps count and sizes
        if (Abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
            err_to_d = 1'b0;
            row_d    = row_q;
            ch_d     = ch_q;
            cnt_d    = cnt_q;
        end
    end

    // state and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            settle_q <= 2'd0;
            wd_q     <= '0;
            row_q    <= '0;
            ch_q     <= '0;
            cnt_q    <= 8'd0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            settle_q <= settle_d;
            wd_q     <= wd_d;
            row_q    <= row_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign Row_Num_Out_REG     = row_q;
    assign Channel_Out_Num_REG = ch_q;
    assign Next_Reg            = (state_q == S_CLEAR);
    assign Start               = (state_q == S_START);
    assign Busy                = (state_q != S_IDLE);
    assign Layer_Done          = (state_q == S_DONE);
    assign Layer_Cnt           = cnt_q;
    assign Err_Cfg             = (state_q == S_LOAD) && !head_valid;
    assign Err_Timeout         = err_to_q;

endmodule
